// File: rtl/colour_box_tracker_if.sv
// Pixel stream in, overlaid pixel stream out and latched bounding box for colour_box_tracker.
// The master side feeds pixels and observes results; the slave side is the tracker.
interface colour_box_tracker_if #(
  parameter int COORD_WIDTH = 11,
  parameter int COLOR_WIDTH = 10
);
  logic                   pix_valid;
  logic [COORD_WIDTH-1:0] pix_x;
  logic [COORD_WIDTH-1:0] pix_y;
  logic [COLOR_WIDTH-1:0] R_in;
  logic [COLOR_WIDTH-1:0] G_in;
  logic [COLOR_WIDTH-1:0] B_in;
  logic [COLOR_WIDTH-1:0] R_out;
  logic [COLOR_WIDTH-1:0] G_out;
  logic [COLOR_WIDTH-1:0] B_out;
  logic                   out_valid;
  logic                   box_valid;
  logic [COORD_WIDTH-1:0] box_x_min;
  logic [COORD_WIDTH-1:0] box_x_max;
  logic [COORD_WIDTH-1:0] box_y_min;
  logic [COORD_WIDTH-1:0] box_y_max;
  logic [18:0]            box_count;

  modport master (
    output pix_valid, pix_x, pix_y, R_in, G_in, B_in,
    input  R_out, G_out, B_out, out_valid,
    input  box_valid, box_x_min, box_x_max, box_y_min, box_y_max, box_count
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, R_in, G_in, B_in,
    output R_out, G_out, B_out, out_valid,
    output box_valid, box_x_min, box_x_max, box_y_min, box_y_max, box_count
  );
endinterface

// File: rtl/colour_box_tracker.sv
// Colour-threshold object tracker: accumulates a per-frame bounding box of matching pixels,
// latches it at frame end and draws the previous frame's box outline onto the pixel stream.
module colour_box_tracker #(
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int COORD_WIDTH = 11,
  parameter int COLOR_WIDTH = 10,
  parameter int R_MIN       = 600,
  parameter int G_MAX       = 300,
  parameter int B_MAX       = 300,
  parameter int MIN_PIXELS  = 64
) (
  input  logic              clock,
  input  logic              aresetn,
  input  logic              enable,
  colour_box_tracker_if.slave bus
);
  localparam int CNT_W = 19;

  typedef logic [COORD_WIDTH-1:0] coord_t;
  typedef logic [COLOR_WIDTH-1:0] colour_t;
  typedef logic [CNT_W-1:0]       count_t;
  typedef enum logic [1:0] {WAIT_SOF, ACCUM, LATCH} state_t;

  localparam coord_t  H_END  = coord_t'(H_ACT);
  localparam coord_t  V_END  = coord_t'(V_ACT);
  localparam coord_t  H_LAST = coord_t'(H_ACT - 1);
  localparam coord_t  V_LAST = coord_t'(V_ACT - 1);
  localparam colour_t R_LO   = colour_t'(R_MIN);
  localparam colour_t G_HI   = colour_t'(G_MAX);
  localparam colour_t B_HI   = colour_t'(B_MAX);
  localparam count_t  CNT_LO = count_t'(MIN_PIXELS);

  function automatic count_t sat_inc(input count_t c);
    return (&c) ? c : c + count_t'(1);
  endfunction

  state_t  state;
  coord_t  x_min_acc, x_max_acc, y_min_acc, y_max_acc;
  count_t  count_acc;
  coord_t  box_x_min_r, box_x_max_r, box_y_min_r, box_y_max_r;
  count_t  box_count_r;
  logic    box_valid_r;
  colour_t r_p1, g_p1, b_p1;
  logic    vld_p1;

  logic   active, match, sof, eof, in_x, in_y, on_border, overlay;
  coord_t base_x_min, base_x_max, base_y_min, base_y_max;
  coord_t nxt_x_min, nxt_x_max, nxt_y_min, nxt_y_max;
  count_t base_count, nxt_count;

  assign active = bus.pix_valid && (bus.pix_x < H_END) && (bus.pix_y < V_END);
  assign match  = active && (bus.R_in >= R_LO) && (bus.G_in <= G_HI) && (bus.B_in <= B_HI);
  assign sof    = active && (bus.pix_x == '0) && (bus.pix_y == '0);
  assign eof    = active && (bus.pix_x == H_LAST) && (bus.pix_y == V_LAST);

  // A SOF pixel restarts the frame, so it is folded into freshly initialised accumulators.
  always_comb begin
    base_x_min = sof ? '1 : x_min_acc;
    base_x_max = sof ? '0 : x_max_acc;
    base_y_min = sof ? '1 : y_min_acc;
    base_y_max = sof ? '0 : y_max_acc;
    base_count = sof ? '0 : count_acc;
    nxt_x_min  = (match && bus.pix_x < base_x_min) ? bus.pix_x : base_x_min;
    nxt_x_max  = (match && bus.pix_x > base_x_max) ? bus.pix_x : base_x_max;
    nxt_y_min  = (match && bus.pix_y < base_y_min) ? bus.pix_y : base_y_min;
    nxt_y_max  = (match && bus.pix_y > base_y_max) ? bus.pix_y : base_y_max;
    nxt_count  = match ? sat_inc(base_count) : base_count;
  end

  assign in_x      = (bus.pix_x >= box_x_min_r) && (bus.pix_x <= box_x_max_r);
  assign in_y      = (bus.pix_y >= box_y_min_r) && (bus.pix_y <= box_y_max_r);
  assign on_border = (((bus.pix_x == box_x_min_r) || (bus.pix_x == box_x_max_r)) && in_y) ||
                     (((bus.pix_y == box_y_min_r) || (bus.pix_y == box_y_max_r)) && in_x);
  assign overlay   = enable && box_valid_r && bus.pix_valid && on_border;

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn || !enable) begin
      state       <= WAIT_SOF;
      x_min_acc   <= '1;
      x_max_acc   <= '0;
      y_min_acc   <= '1;
      y_max_acc   <= '0;
      count_acc   <= '0;
      box_x_min_r <= '0;
      box_x_max_r <= '0;
      box_y_min_r <= '0;
      box_y_max_r <= '0;
      box_count_r <= '0;
      box_valid_r <= 1'b0;
    end else begin
      case (state)
        WAIT_SOF: begin
          if (sof) begin
            x_min_acc <= nxt_x_min;
            x_max_acc <= nxt_x_max;
            y_min_acc <= nxt_y_min;
            y_max_acc <= nxt_y_max;
            count_acc <= nxt_count;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          x_min_acc <= nxt_x_min;
          x_max_acc <= nxt_x_max;
          y_min_acc <= nxt_y_min;
          y_max_acc <= nxt_y_max;
          count_acc <= nxt_count;
          if (eof && !sof) state <= LATCH;
        end
        LATCH: begin
          box_x_min_r <= x_min_acc;
          box_x_max_r <= x_max_acc;
          box_y_min_r <= y_min_acc;
          box_y_max_r <= y_max_acc;
          box_count_r <= count_acc;
          box_valid_r <= (count_acc >= CNT_LO);
          x_min_acc   <= '1;
          x_max_acc   <= '0;
          y_min_acc   <= '1;
          y_max_acc   <= '0;
          count_acc   <= '0;
          state       <= WAIT_SOF;
        end
        default: state <= WAIT_SOF;
      endcase
    end
  end

  // Stage p1: registered pixel outputs with the box outline overlaid.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      vld_p1 <= 1'b0;
      r_p1   <= '0;
      g_p1   <= '0;
      b_p1   <= '0;
    end else begin
      vld_p1 <= bus.pix_valid;
      r_p1   <= overlay ? '0 : bus.R_in;
      g_p1   <= overlay ? '1 : bus.G_in;
      b_p1   <= overlay ? '0 : bus.B_in;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.R_out     = r_p1;
  assign bus.G_out     = g_p1;
  assign bus.B_out     = b_p1;
  assign bus.box_valid = box_valid_r;
  assign bus.box_x_min = box_x_min_r;
  assign bus.box_x_max = box_x_max_r;
  assign bus.box_y_min = box_y_min_r;
  assign bus.box_y_max = box_y_max_r;
  assign bus.box_count = box_count_r;
endmodule

// File: tb/tb_colour_box_tracker.sv
// Bench for colour_box_tracker on a reduced 32x24 frame: table of blob frames with expected boxes,
// a pixel scoreboard for the overlay stream, and hand-written reset / early-SOF / enable sequences.
module tb_colour_box_tracker;
  localparam int HA = 32;
  localparam int VA = 24;
  localparam int CW = 11;
  localparam int KW = 10;

  logic clock = 1'b0;
  logic aresetn;
  logic enable;

  colour_box_tracker_if #(.COORD_WIDTH(CW), .COLOR_WIDTH(KW)) bus();

  colour_box_tracker #(
    .H_ACT(HA), .V_ACT(VA), .COORD_WIDTH(CW), .COLOR_WIDTH(KW),
    .R_MIN(600), .G_MAX(300), .B_MAX(300), .MIN_PIXELS(64)
  ) dut (
    .clock(clock),
    .aresetn(aresetn),
    .enable(enable),
    .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {int x0; int x1; int y0; int y1; int r; int g; int b;} rect_t;
  typedef struct packed {rect_t a; rect_t b; rect_t c;
                         int vld; int xmin; int xmax; int ymin; int ymax; int cnt;} vec_t;
  typedef struct packed {logic v; logic [KW-1:0] r; logic [KW-1:0] g; logic [KW-1:0] b;} exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  rect_t cur_a, cur_b, cur_c;
  int    ov_valid = 0;
  int    ov_x0 = 0, ov_x1 = 0, ov_y0 = 0, ov_y1 = 0;
  vec_t  vecs[4];

  function automatic rect_t mk(int x0, int x1, int y0, int y1, int r, int g, int b);
    rect_t q;
    q.x0 = x0; q.x1 = x1; q.y0 = y0; q.y1 = y1; q.r = r; q.g = g; q.b = b;
    return q;
  endfunction

  function automatic bit in_rect(rect_t q, int x, int y);
    return (x >= q.x0) && (x <= q.x1) && (y >= q.y0) && (y <= q.y1);
  endfunction

  function automatic void colour_at(input int x, input int y, output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    if (in_rect(cur_a, x, y)) begin r = cur_a.r; g = cur_a.g; b = cur_a.b; end
    if (in_rect(cur_b, x, y)) begin r = cur_b.r; g = cur_b.g; b = cur_b.b; end
    if (in_rect(cur_c, x, y)) begin r = cur_c.r; g = cur_c.g; b = cur_c.b; end
  endfunction

  function automatic bit border(int x, int y);
    bit ix, iy;
    ix = (x >= ov_x0) && (x <= ov_x1);
    iy = (y >= ov_y0) && (y <= ov_y1);
    return (((x == ov_x0) || (x == ov_x1)) && iy) || (((y == ov_y0) || (y == ov_y1)) && ix);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_out();
    exp_t e;
    exp_t g;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = {bus.out_valid, bus.R_out, bus.G_out, bus.B_out};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL pixel got v%0d rgb %0d/%0d/%0d expected v%0d rgb %0d/%0d/%0d at %0t",
                 g.v, g.r, g.g, g.b, e.v, e.r, e.g, e.b, $time);
      end
    end
  endtask

  task automatic cyc(input int v, input int x, input int y, input int r, input int g, input int b,
                     input int en);
    exp_t e;
    @(negedge clock);
    check_out();
    enable        = en[0];
    bus.pix_valid = v[0];
    bus.pix_x     = CW'(x);
    bus.pix_y     = CW'(y);
    bus.R_in      = KW'(r);
    bus.G_in      = KW'(g);
    bus.B_in      = KW'(b);
    e.v = v[0];
    if (en != 0 && ov_valid != 0 && v != 0 && border(x, y)) begin
      e.r = '0; e.g = '1; e.b = '0;
    end else begin
      e.r = KW'(r); e.g = KW'(g); e.b = KW'(b);
    end
    sb.push_back(e);
    if (en == 0) ov_valid = 0;
  endtask

  // Drives pixels by linear index; after each row an out-of-range red pixel must be ignored.
  task automatic frame_pixels(input int first, input int last, input int en);
    int r, g, b;
    for (int idx = first; idx <= last; idx++) begin
      colour_at(idx % HA, idx / HA, r, g, b);
      cyc(1, idx % HA, idx / HA, r, g, b, en);
      if (idx % HA == HA - 1) cyc(1, HA, idx / HA, 1023, 0, 0, en);
    end
  endtask

  task automatic idle(input int n, input int en);
    for (int i = 0; i < n; i++)
      cyc(0, $urandom_range(0, 40), 0, $urandom_range(0, 1023), $urandom_range(0, 1023),
          $urandom_range(0, 1023), en);
  endtask

  task automatic check_box(input string tag, input int vld, input int xmin, input int xmax,
                           input int ymin, input int ymax, input int cnt);
    chk({tag, "_valid"}, int'(bus.box_valid), vld);
    chk({tag, "_xmin"},  int'(bus.box_x_min), xmin);
    chk({tag, "_xmax"},  int'(bus.box_x_max), xmax);
    chk({tag, "_ymin"},  int'(bus.box_y_min), ymin);
    chk({tag, "_ymax"},  int'(bus.box_y_max), ymax);
    chk({tag, "_count"}, int'(bus.box_count), cnt);
  endtask

  task automatic set_overlay(input int vld, input int x0, input int x1, input int y0, input int y1);
    ov_valid = vld; ov_x0 = x0; ov_x1 = x1; ov_y0 = y0; ov_y1 = y1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_rgb"}, int'({bus.R_out, bus.G_out, bus.B_out}), 0);
    check_box(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rect_t none;
    none = mk(1, 0, 1, 0, 0, 0, 0);
    enable = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_x = '0; bus.pix_y = '0;
    bus.R_in = '0; bus.G_in = '0; bus.B_in = '0;
    aresetn = 1'b1;
    #1 aresetn = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clock);
    aresetn = 1'b1;

    // blob; below threshold with a B=301 decoy; threshold edges at exactly MIN_PIXELS; full frame
    vecs[0] = '{a: mk(10, 19, 5, 14, 1023, 0, 0), b: none, c: none,
                vld: 1, xmin: 10, xmax: 19, ymin: 5, ymax: 14, cnt: 100};
    vecs[1] = '{a: mk(3, 7, 2, 6, 1023, 0, 0), b: mk(20, 25, 10, 15, 1023, 0, 301), c: none,
                vld: 0, xmin: 3, xmax: 7, ymin: 2, ymax: 6, cnt: 25};
    vecs[2] = '{a: mk(0, 7, 0, 7, 600, 300, 300), b: mk(8, 15, 0, 7, 599, 300, 300),
                c: mk(16, 23, 0, 7, 1023, 301, 300),
                vld: 1, xmin: 0, xmax: 7, ymin: 0, ymax: 7, cnt: 64};
    vecs[3] = '{a: mk(0, HA - 1, 0, VA - 1, 1023, 0, 0), b: none, c: none,
                vld: 1, xmin: 0, xmax: HA - 1, ymin: 0, ymax: VA - 1, cnt: HA * VA};

    for (int i = 0; i < 4; i++) begin
      cur_a = vecs[i].a; cur_b = vecs[i].b; cur_c = vecs[i].c;
      frame_pixels(0, HA * VA - 1, 1);
      idle(4, 1);
      check_box($sformatf("vec%0d", i), vecs[i].vld, vecs[i].xmin, vecs[i].xmax,
                vecs[i].ymin, vecs[i].ymax, vecs[i].cnt);
      set_overlay(vecs[i].vld, vecs[i].xmin, vecs[i].xmax, vecs[i].ymin, vecs[i].ymax);
    end

    // Early SOF: 30 matching pixels in a partial frame, then a restarted full frame.
    cur_a = mk(0, 9, 0, 2, 1023, 0, 0); cur_b = none; cur_c = none;
    frame_pixels(0, 6 * HA - 1, 1);
    cur_a = mk(10, 19, 5, 14, 1023, 0, 0);
    frame_pixels(0, HA * VA - 1, 1);
    idle(4, 1);
    check_box("early_sof", 1, 10, 19, 5, 14, 100);
    set_overlay(1, 10, 19, 5, 14);

    // Mid-frame reset: outputs drop at once; the tail of the frame must not latch.
    frame_pixels(0, 10 * HA - 1, 1);
    @(negedge clock);
    check_out();
    #2 aresetn = 1'b0;
    #1 check_all_zero("mid_reset");
    sb.delete();
    set_overlay(0, 0, 0, 0, 0);
    @(negedge clock);
    aresetn = 1'b1;
    frame_pixels(10 * HA, HA * VA - 1, 1);
    idle(4, 1);
    check_box("after_reset_tail", 0, 0, 0, 0, 0, 0);
    frame_pixels(0, HA * VA - 1, 1);
    idle(4, 1);
    check_box("after_reset_frame", 1, 10, 19, 5, 14, 100);
    set_overlay(1, 10, 19, 5, 14);

    // Enable dropped mid-frame with a valid box.
    frame_pixels(0, 8 * HA - 1, 1);
    cyc(1, 0, 8, 0, 0, 0, 0);
    @(posedge clock);
    #1 check_box("enable_off", 0, 0, 0, 0, 0, 0);
    frame_pixels(8 * HA + 1, HA * VA - 1, 0);
    idle(4, 0);
    check_box("enable_off_eof", 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    check_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
